// File: rtl/pkt_mem_if.sv
// Request/response bundle between the switch memory controller (master)
// and the packet buffer responder (slave).
interface pkt_mem_if;
  logic [1:0]  req;
  logic [16:0] address;
  logic [63:0] writedata;
  logic        resp;
  logic [63:0] readdata;
  logic        err;
  logic        busy;

  modport master (
    output req, address, writedata,
    input  resp, readdata, err, busy
  );

  modport slave (
    input  req, address, writedata,
    output resp, readdata, err, busy
  );
endinterface

// File: rtl/pkt_mem_responder.sv
// Packet buffer memory responder: one request at a time, fixed-latency resp pulse.
// Optional PKT_MEM_STATS_EN adds saturating good-write/good-read counters.
module pkt_mem_responder #(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  pkt_mem_if.slave    bus
`ifdef PKT_MEM_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                errLat_q;
  logic                readLat_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [63:0]         readdata_q;

  logic                accept;
  logic                respEntry;
  logic                reqLegal;
  logic                inRange;
  logic                commitWrite;

  logic [63:0]         mem [2**ADDR_W];

  assign reqLegal    = (bus.req == 2'b01) || (bus.req == 2'b10);
  assign inRange     = (bus.address >> ADDR_W) == 17'd0;
  assign commitWrite = accept && !reset && (bus.req == 2'b01) && inRange;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    respEntry = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          accept  = 1'b1;
          cnt_d   = CntLoad;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          respEntry = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Error and access kind are resolved at accept so only the word index is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      errLat_q   <= 1'b0;
      readLat_q  <= 1'b0;
      idx_q      <= '0;
      readdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        errLat_q  <= !reqLegal || !inRange;
        readLat_q <= (bus.req == 2'b10);
        idx_q     <= bus.address[ADDR_W-1:0];
      end
      if (respEntry && readLat_q) begin
        readdata_q <= errLat_q ? 64'd0 : mem[idx_q];
      end
    end
  end

  // Array contents survive reset, so the storage has no reset branch.
  always_ff @(posedge clk) begin
    if (commitWrite) begin
      mem[bus.address[ADDR_W-1:0]] <= bus.writedata;
    end
  end

  assign bus.resp     = (state_q == S_RESP);
  assign bus.err      = (state_q == S_RESP) && errLat_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.readdata = readdata_q;

`ifdef PKT_MEM_STATS_EN
  logic [15:0] wrCnt_q;
  logic [15:0] rdCnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrCnt_q <= 16'd0;
      rdCnt_q <= 16'd0;
    end else if (respEntry && !errLat_q) begin
      if (readLat_q) begin
        if (rdCnt_q != 16'hFFFF) rdCnt_q <= rdCnt_q + 16'd1;
      end else begin
        if (wrCnt_q != 16'hFFFF) wrCnt_q <= wrCnt_q + 16'd1;
      end
    end
  end

  assign wr_count = wrCnt_q;
  assign rd_count = rdCnt_q;
`endif

endmodule
